// File: rtl/fifo_reader.sv
// fifo_reader: pops a synchronous FIFO and re-times its one-cycle read latency through a
// 2-entry buffer into a valid/ready stream. Define FIFO_READER_CHECK_EN to build the err checker.
module fifo_reader #(
    parameter int FIFO_WIDTH = 16,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic                  empty,
    input  logic                  underflow,
    input  logic [FIFO_WIDTH-1:0] data_out,
    output logic                  rd_en,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [FIFO_WIDTH-1:0] m_data,
    output logic [CNT_WIDTH-1:0]  rd_count,
    output logic                  err
);

    logic [1:0]            occ;
    logic                  inflight;
    logic                  wr_ptr;
    logic                  rd_ptr;
    logic [FIFO_WIDTH-1:0] data_buf [2];
    logic                  pop;
    logic [1:0]            level;

    // Words buffered or already requested after this cycle's pop; a read is only issued
    // when the buffer is guaranteed a free slot for its returning data.
    assign pop     = m_valid && m_ready;
    assign level   = occ + {1'b0, inflight} - {1'b0, pop};
    assign rd_en   = !rst && enable && !empty && (level < 2'd2);
    assign m_valid = (occ != 2'd0);
    assign m_data  = data_buf[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            occ         <= 2'd0;
            inflight    <= 1'b0;
            wr_ptr      <= 1'b0;
            rd_ptr      <= 1'b0;
            data_buf[0] <= '0;
            data_buf[1] <= '0;
            rd_count    <= '0;
        end else begin
            if (inflight) begin
                data_buf[wr_ptr] <= data_out;
                wr_ptr           <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr   <= ~rd_ptr;
                rd_count <= rd_count + CNT_WIDTH'(1);
            end
            occ      <= level;
            inflight <= rd_en;
        end
    end

`ifdef FIFO_READER_CHECK_EN
    logic err_q;

    // Sticky: the FIFO refused a read we issued, or we tried to read an empty FIFO.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if ((inflight && underflow) || (rd_en && empty)) begin
            err_q <= 1'b1;
        end
    end

    assign err = err_q;
`else
    logic unused_underflow;

    assign unused_underflow = underflow;
    assign err              = 1'b0;
`endif

endmodule
